posterior_counter: RTL and testbench
====================================

POSTERIOR_COUNTER -- requirements
Module: posterior_counter

Interface
REQ-001 SHALL have parameter Narray, default 2, log2 of the number of stochastic output lanes (one per likelihood-array row).
REQ-002 SHALL have parameter CNT_W, default 10, width of the per-lane and window counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a counting window.
REQ-006 SHALL have port window_len  input  CNT_W  number of samples per window; sampled when start is accepted.
REQ-007 SHALL have port stoch_log  input  1  computing mode: 0 stochastic, 1 logarithmic.
REQ-008 SHALL have port bit_in  input  2**Narray  stochastic posterior bits, one per lane, from the Bayesian array bit_out.
REQ-009 SHALL have port sample_valid  input  1  bit_in holds a valid sample this cycle.
REQ-010 SHALL have port busy  output  1  high in COUNT and DONE.
REQ-011 SHALL have port result_valid  output  1  result available; held until accepted.
REQ-012 SHALL have port result_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port winner  output  Narray  index of the lane with the highest count.
REQ-014 SHALL have port winner_count  output  CNT_W  count of the winning lane.
REQ-015 SHALL have port tie  output  1  more than one lane shares the maximum count.

Function
REQ-016 SHALL implement FSM states IDLE, COUNT, DONE.
REQ-017 SHALL, in IDLE, on start=1 with window_len!=0 and stoch_log=0, clear all lane counters and the sample counter, latch window_len, and enter COUNT next cycle.
REQ-018 SHALL ignore start in IDLE when window_len=0 or stoch_log=1 (remain IDLE, no output change).
REQ-019 SHALL, in COUNT, on each cycle with sample_valid=1, increment lane counter k by 1 for every k with bit_in[k]=1, and increment the sample counter by 1.
REQ-020 SHALL ignore cycles with sample_valid=0 (counters hold).
REQ-021 SHALL, on the accepted sample that makes the sample counter equal the latched window_len, include that sample, then enter DONE next cycle with result_valid=1 (latency: result_valid one cycle after the last sample).
REQ-022 SHALL compute the argmax over the final lane counts (including the last sample) and register winner, winner_count, tie on the COUNT->DONE transition.
REQ-023 SHALL resolve ties to the lowest lane index and set tie=1 when two or more lanes equal the maximum; tie=0 otherwise.
REQ-024 SHALL saturate each lane counter at 2**CNT_W-1 (no wrap-around).
REQ-025 SHALL ignore start while in COUNT and ignore sample_valid while in IDLE or DONE.
REQ-026 SHALL, if stoch_log becomes 1 during COUNT, abort: return to IDLE next cycle, clear counters, no result produced.
REQ-027 SHALL, in DONE, hold result_valid, winner, winner_count, tie stable until result_valid=1 and result_ready=1 in the same cycle.
REQ-028 SHALL, on handshake in DONE, deassert result_valid next cycle and enter IDLE; if start=1 with window_len!=0 and stoch_log=0 in the same cycle, enter COUNT directly with cleared counters.
REQ-029 SHALL keep winner, winner_count, tie at their last registered values in IDLE and COUNT.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, force state IDLE, all counters 0, busy=0, result_valid=0, winner=0, winner_count=0, tie=0, overriding all other inputs, including mid-window or in DONE.

Verification
REQ-031 SHALL cover: start, window_len=8, 8 valid samples bit_in=4'b0100 -> result_valid one cycle after 8th sample, winner=2, winner_count=8, tie=0.
REQ-032 SHALL cover: window_len=4, samples 4'b0011,4'b0011,4'b0001,4'b0010 -> winner=0, winner_count=3, tie=1; sample_valid gaps between samples do not change the result.
REQ-033 SHALL cover: result_ready held low 5 cycles in DONE -> outputs stable; start during DONE without handshake ignored; handshake with start=1 -> COUNT next cycle, counters 0.
REQ-034 SHALL cover: start with window_len=0, or with stoch_log=1 -> stays IDLE, busy=0; stoch_log rising mid-COUNT -> IDLE, no result_valid.
REQ-035 SHALL cover: CNT_W=4, window_len=15, all lanes 1 every sample -> winner=0, winner_count=15, tie=1, no wrap.
REQ-036 SHALL cover: rst asserted after 3 of 8 samples -> all outputs 0 next cycle; new start counts from zero.

Source files
------------

// File: rtl/posterior_counter.sv
// Posterior counter: tallies stochastic posterior bits per lane over a
// window of valid samples, then reports the lane with the highest count
// (lowest index on ties) through a valid/ready result handshake.
module posterior_counter #(
    parameter int Narray = 2,
    parameter int CNT_W  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       window_len,
    input  logic                   stoch_log,
    input  logic [2**Narray-1:0]   bit_in,
    input  logic                   sample_valid,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [Narray-1:0]      winner,
    output logic [CNT_W-1:0]       winner_count,
    output logic                   tie
);

    localparam int LANES = 2**Narray;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   lane_q [LANES];
    logic [CNT_W-1:0]   lane_d [LANES];
    logic [CNT_W-1:0]   lane_inc [LANES];
    logic [CNT_W-1:0]   samp_q, samp_d;
    logic [CNT_W-1:0]   samp_inc;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [Narray-1:0]  winner_q, winner_d;
    logic [CNT_W-1:0]   wcount_q, wcount_d;
    logic               tie_q, tie_d;

    logic [Narray-1:0]  best_idx;
    logic [CNT_W-1:0]   best_cnt;
    logic               best_tie;
    logic               start_ok;

    // A start is only honoured in stochastic mode with a non-empty window.
    assign start_ok = start && (window_len != '0) && !stoch_log;
    assign samp_inc = samp_q + CNT_W'(1);

    // Per-lane saturating increment of the counts as they would be after this sample.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_inc[gi] = (bit_in[gi] && (lane_q[gi] != CNT_MAX))
                                ? lane_q[gi] + CNT_W'(1) : lane_q[gi];
        end
    endgenerate

    // Argmax over the post-sample counts so the final sample is included.
    always_comb begin
        best_idx = '0;
        best_cnt = lane_inc[0];
        best_tie = 1'b0;
        for (int i = 1; i < LANES; i++) begin
            if (lane_inc[i] > best_cnt) begin
                best_idx = Narray'(i);
                best_cnt = lane_inc[i];
                best_tie = 1'b0;
            end else if (lane_inc[i] == best_cnt) begin
                best_tie = 1'b1;
            end
        end
    end

    // Next-state, counter and result-register logic.
    always_comb begin
        state_d  = state_q;
        samp_d   = samp_q;
        len_d    = len_q;
        winner_d = winner_q;
        wcount_d = wcount_q;
        tie_d    = tie_q;
        for (int i = 0; i < LANES; i++) begin
            lane_d[i] = lane_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_COUNT;
                    len_d   = window_len;
                    samp_d  = '0;
                    for (int i = 0; i < LANES; i++) lane_d[i] = '0;
                end
            end
            S_COUNT: begin
                if (stoch_log) begin
                    // Mode switch aborts the window without producing a result.
                    state_d = S_IDLE;
                    samp_d  = '0;
                    for (int i = 0; i < LANES; i++) lane_d[i] = '0;
                end else if (sample_valid) begin
                    samp_d = samp_inc;
                    for (int i = 0; i < LANES; i++) lane_d[i] = lane_inc[i];
                    if (samp_inc == len_q) begin
                        state_d  = S_DONE;
                        winner_d = best_idx;
                        wcount_d = best_cnt;
                        tie_d    = best_tie;
                    end
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    if (start_ok) begin
                        state_d = S_COUNT;
                        len_d   = window_len;
                        samp_d  = '0;
                        for (int i = 0; i < LANES; i++) lane_d[i] = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            samp_q   <= '0;
            len_q    <= '0;
            winner_q <= '0;
            wcount_q <= '0;
            tie_q    <= 1'b0;
            for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            samp_q   <= samp_d;
            len_q    <= len_d;
            winner_q <= winner_d;
            wcount_q <= wcount_d;
            tie_q    <= tie_d;
            for (int i = 0; i < LANES; i++) lane_q[i] <= lane_d[i];
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_DONE);
    assign winner       = winner_q;
    assign winner_count = wcount_q;
    assign tie          = tie_q;

endmodule

// File: tb/tb_posterior_counter.sv
// Bench for posterior_counter: directed scenarios plus randomized windows
// checked against a count-then-argmax reference model.
module tb_posterior_counter;

    localparam int NA = 2;
    localparam int W  = 10;
    localparam int L  = 4;
    localparam int W4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start, stoch_log, sample_valid, result_ready;
    logic [W-1:0]  window_len;
    logic [L-1:0]  bit_in;
    logic          busy, result_valid, tie;
    logic [NA-1:0] winner;
    logic [W-1:0]  winner_count;

    logic          start_s, stoch_log_s, sample_valid_s, result_ready_s;
    logic [W4-1:0] window_len_s;
    logic [L-1:0]  bit_in_s;
    logic          busy_s, result_valid_s, tie_s;
    logic [NA-1:0] winner_s;
    logic [W4-1:0] winner_count_s;

    int checks = 0;
    int errors = 0;

    posterior_counter #(.Narray(NA), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .window_len(window_len),
        .stoch_log(stoch_log), .bit_in(bit_in), .sample_valid(sample_valid),
        .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
        .winner(winner), .winner_count(winner_count), .tie(tie)
    );

    posterior_counter #(.Narray(NA), .CNT_W(W4)) dut_small (
        .clk(clk), .rst(rst), .start(start_s), .window_len(window_len_s),
        .stoch_log(stoch_log_s), .bit_in(bit_in_s), .sample_valid(sample_valid_s),
        .busy(busy_s), .result_valid(result_valid_s), .result_ready(result_ready_s),
        .winner(winner_s), .winner_count(winner_count_s), .tie(tie_s)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_window(input int len);
        start = 1'b1;
        window_len = W'(len);
        tick();
        start = 1'b0;
    endtask

    // gap idle cycles with junk bits, then one valid sample (optionally with a stray start)
    task automatic feed(input logic [L-1:0] b, input int gap, input logic stray_start);
        repeat (gap) begin
            sample_valid = 1'b0;
            bit_in = L'($urandom);
            tick();
        end
        sample_valid = 1'b1;
        bit_in = b;
        start = stray_start;
        tick();
        sample_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    // Reference: count lanes, clip at the counter ceiling, pick the first maximal lane.
    function automatic void ref_argmax(input int cnt[L], input int cap,
                                       output int w, output int wc, output bit t);
        int sat[L];
        int m;
        int n;
        m = 0;
        for (int k = 0; k < L; k++) begin
            sat[k] = (cnt[k] > cap) ? cap : cnt[k];
            if (sat[k] > m) m = sat[k];
        end
        w = -1;
        n = 0;
        for (int k = 0; k < L; k++) begin
            if (sat[k] == m) begin
                n++;
                if (w < 0) w = k;
            end
        end
        wc = m;
        t = (n > 1);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        start = 0; stoch_log = 0; sample_valid = 0; result_ready = 0;
        window_len = '0; bit_in = '0;
        start_s = 0; stoch_log_s = 0; sample_valid_s = 0; result_ready_s = 0;
        window_len_s = '0; bit_in_s = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", result_valid); end
        checks++; if (winner !== '0) begin errors++; $display("FAIL reset_winner got %0d want 0", winner); end
        checks++; if (winner_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", winner_count); end
        checks++; if (tie !== 1'b0) begin errors++; $display("FAIL reset_tie got %0b want 0", tie); end
    endtask

    task automatic test_single_lane();
        start_window(8);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0b want 1", busy); end
        for (int i = 0; i < 7; i++) feed(4'b0100, 0, 1'b0);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b want 0", result_valid); end
        feed(4'b0100, 0, 1'b0);
        checks++; if ({result_valid, winner, winner_count, tie} !== {1'b1, 2'd2, 10'd8, 1'b0})
            begin errors++; $display("FAIL single_result got v=%0b w=%0d c=%0d t=%0b want v=1 w=2 c=8 t=0", result_valid, winner, winner_count, tie); end
        handshake();
        checks++; if ({busy, result_valid, winner, winner_count} !== {1'b0, 1'b0, 2'd2, 10'd8})
            begin errors++; $display("FAIL single_after_hs got b=%0b v=%0b w=%0d c=%0d want b=0 v=0 w=2 c=8", busy, result_valid, winner, winner_count); end
    endtask

    task automatic test_tie_gaps();
        start_window(4);
        feed(4'b0011, 2, 1'b0);
        feed(4'b0011, 0, 1'b0);
        feed(4'b0001, 3, 1'b0);
        feed(4'b0010, 1, 1'b0);
        checks++; if ({result_valid, winner, winner_count, tie} !== {1'b1, 2'd0, 10'd3, 1'b1})
            begin errors++; $display("FAIL tie_result got v=%0b w=%0d c=%0d t=%0b want v=1 w=0 c=3 t=1", result_valid, winner, winner_count, tie); end
        handshake();
    endtask

    task automatic test_done_hold();
        start_window(8);
        for (int i = 0; i < 8; i++) feed(4'b0100, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            window_len = 10'd5;
            tick();
            start = 1'b0;
            checks++; if ({result_valid, winner, winner_count, tie} !== {1'b1, 2'd2, 10'd8, 1'b0})
                begin errors++; $display("FAIL hold_cycle%0d got v=%0b w=%0d c=%0d t=%0b want v=1 w=2 c=8 t=0", i, result_valid, winner, winner_count, tie); end
        end
        start = 1'b1;
        window_len = 10'd3;
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        result_ready = 1'b0;
        checks++; if ({busy, result_valid} !== 2'b10)
            begin errors++; $display("FAIL hs_restart got b=%0b v=%0b want b=1 v=0", busy, result_valid); end
        for (int i = 0; i < 3; i++) feed(4'b1000, 0, 1'b0);
        checks++; if ({result_valid, winner, winner_count, tie} !== {1'b1, 2'd3, 10'd3, 1'b0})
            begin errors++; $display("FAIL restart_result got v=%0b w=%0d c=%0d t=%0b want v=1 w=3 c=3 t=0", result_valid, winner, winner_count, tie); end
        handshake();
    endtask

    task automatic test_ignored_start();
        start_window(0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_len_busy got %0b want 0", busy); end
        stoch_log = 1'b1;
        start_window(5);
        stoch_log = 1'b0;
        checks++; if ({busy, winner, winner_count} !== {1'b0, 2'd3, 10'd3})
            begin errors++; $display("FAIL log_mode_start got b=%0b w=%0d c=%0d want b=0 w=3 c=3", busy, winner, winner_count); end
        start_window(8);
        feed(4'b0001, 0, 1'b0);
        feed(4'b0001, 0, 1'b0);
        stoch_log = 1'b1;
        sample_valid = 1'b1;
        bit_in = 4'b0001;
        tick();
        stoch_log = 1'b0;
        checks++; if ({busy, result_valid} !== 2'b00)
            begin errors++; $display("FAIL abort got b=%0b v=%0b want b=0 v=0", busy, result_valid); end
        repeat (10) tick();
        sample_valid = 1'b0;
        checks++; if ({busy, result_valid} !== 2'b00)
            begin errors++; $display("FAIL idle_samples got b=%0b v=%0b want b=0 v=0", busy, result_valid); end
        start_window(2);
        feed(4'b0010, 0, 1'b0);
        feed(4'b0010, 0, 1'b0);
        checks++; if ({result_valid, winner, winner_count, tie} !== {1'b1, 2'd1, 10'd2, 1'b0})
            begin errors++; $display("FAIL post_abort got v=%0b w=%0d c=%0d t=%0b want v=1 w=1 c=2 t=0", result_valid, winner, winner_count, tie); end
        handshake();
    endtask

    task automatic test_saturate();
        start_s = 1'b1;
        window_len_s = 4'd15;
        tick();
        start_s = 1'b0;
        sample_valid_s = 1'b1;
        bit_in_s = 4'b1111;
        repeat (15) tick();
        sample_valid_s = 1'b0;
        checks++; if ({result_valid_s, winner_s, winner_count_s, tie_s} !== {1'b1, 2'd0, 4'd15, 1'b1})
            begin errors++; $display("FAIL small_full got v=%0b w=%0d c=%0d t=%0b want v=1 w=0 c=15 t=1", result_valid_s, winner_s, winner_count_s, tie_s); end
        result_ready_s = 1'b1;
        tick();
        result_ready_s = 1'b0;
        checks++; if (result_valid_s !== 1'b0) begin errors++; $display("FAIL small_hs got %0b want 0", result_valid_s); end
    endtask

    task automatic test_reset_mid();
        start_window(8);
        for (int i = 0; i < 3; i++) feed(4'b0010, 0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({busy, result_valid, winner, winner_count, tie} !== {1'b0, 1'b0, 2'd0, 10'd0, 1'b0})
            begin errors++; $display("FAIL mid_reset got b=%0b v=%0b w=%0d c=%0d t=%0b want all 0", busy, result_valid, winner, winner_count, tie); end
        start_window(2);
        feed(4'b0010, 0, 1'b0);
        feed(4'b0010, 0, 1'b0);
        checks++; if ({result_valid, winner, winner_count, tie} !== {1'b1, 2'd1, 10'd2, 1'b0})
            begin errors++; $display("FAIL after_reset got v=%0b w=%0d c=%0d t=%0b want v=1 w=1 c=2 t=0", result_valid, winner, winner_count, tie); end
        handshake();
    endtask

    task automatic test_random();
        int cnt[L];
        int len, ew, ewc;
        bit et;
        logic [L-1:0] b;
        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < L; k++) cnt[k] = 0;
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 1) == 1) begin
                sample_valid = 1'b1;
                bit_in = L'($urandom);
                tick();
                sample_valid = 1'b0;
            end
            start_window(len);
            for (int s = 0; s < len; s++) begin
                b = L'($urandom);
                for (int k = 0; k < L; k++) if (b[k]) cnt[k]++;
                feed(b, $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0));
            end
            ref_argmax(cnt, (1 << W) - 1, ew, ewc, et);
            checks++; if ({result_valid, winner, winner_count, tie} !== {1'b1, NA'(ew), W'(ewc), et})
                begin errors++; $display("FAIL rand%0d got v=%0b w=%0d c=%0d t=%0b want v=1 w=%0d c=%0d t=%0b", n, result_valid, winner, winner_count, tie, ew, ewc, et); end
            repeat ($urandom_range(0, 3)) tick();
            checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL rand%0d_hold got %0b want 1", n, result_valid); end
            handshake();
            checks++; if ({busy, result_valid} !== 2'b00)
                begin errors++; $display("FAIL rand%0d_hs got b=%0b v=%0b want 0 0", n, busy, result_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_tie_gaps();
        test_done_hold();
        test_ignored_start();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
